reg4_write_arbiter: RTL
=======================

Name: reg4_write_arbiter

Overview:
- Shares one 4-bit `ce`-gated register among `N_REQ` requesters.
- Grants round-robin, latches the winner's data, drives `reg_ce`/`reg_d` for exactly one write cycle, then returns a one-cycle `ack` to the winner.
- Sits in front of the register's `d`/`ce` inputs. It is the only driver of those pins.

Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `WIDTH`, 4, data width of the shared register.
- `IDX_W`, 2, width of the owner index; must satisfy 2^`IDX_W` >= `N_REQ`.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous active-high reset.
- `req`  in  `N_REQ`  per-requester write request, level.
- `d_in`  in  `N_REQ`*`WIDTH`  requester data; slice i is `d_in[i*WIDTH +: WIDTH]`.
- `gnt`  out  `N_REQ`  one-hot grant, registered.
- `ack`  out  `N_REQ`  one-hot write-done pulse, registered.
- `reg_ce`  out  1  clock enable to the shared register.
- `reg_d`  out  `WIDTH`  data to the shared register.
- `owner`  out  `IDX_W`  index of the current or last granted requester.
- `busy`  out  1  high in WRITE and ACK.

Behaviour:
- Reset (`clr`=1, asynchronous):
  - state=IDLE.
  - `gnt`, `ack`, `reg_ce`, `reg_d`, `busy` = 0.
  - `owner`=0.
  - rr pointer = `N_REQ`-1, so `req[0]` has top priority after reset.
- All outputs come straight from flops. No combinational path from `req`/`d_in` to outputs.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If `req`==0, stay.
  - Otherwise pick the first set bit searching upward from rr+1 with wrap-around (index `N_REQ`-1 is followed by 0).
  - At that edge, register:
    - `owner`=winner and rr=winner.
    - `gnt`=onehot(winner).
    - latched data = winner's `d_in` slice.
    - `reg_ce`=1 and `busy`=1.
  - Go to WRITE.
- WRITE (exactly 1 cycle):
  - `reg_ce`=1 and `reg_d`=latched data. The register captures at the end of this cycle.
  - Next edge: `reg_ce`=0, `ack`=onehot(owner). Go to ACK.
- ACK (exactly 1 cycle):
  - `gnt` and `ack` are held for owner; `busy`=1.
  - Next edge: `gnt`=0, `ack`=0, `busy`=0. Go to IDLE.
- `reg_d` holds the last written value outside WRITE. The register ignores it because `reg_ce`=0.
- Latency: `req` sampled high in IDLE at edge E gives:
  - `reg_ce` high in cycle E+1.
  - `ack` high in cycle E+2.
  - IDLE again in cycle E+3.
- Minimum spacing between writes is 3 cycles.
- Requester protocol: drop `req` on the edge where `ack` is sampled high. If `req` is still high in IDLE, it is treated as a new request under round-robin rules.
- Changes on `req` or `d_in` during WRITE/ACK:
  - Ignored. The write completes with the latched data and `ack` is still issued, even if the owner has withdrawn `req`.
  - Requests from other requesters wait for IDLE.
- Fairness: with all `req` bits continuously high, grants rotate 0,1,...,`N_REQ`-1,0,...
- `clr` mid-operation (WRITE or ACK):
  - All outputs clear immediately, no `ack` is issued, and the write is aborted.
  - `reg_ce` drops asynchronously.
  - After release, pending requests are re-arbitrated from rr=`N_REQ`-1.
- `clr` high across a rising edge: state held in reset, no arbitration.

Test Plan:
1. Reset: `clr`=1 with `req`=4'b1111 → `gnt`=0, `ack`=0, `reg_ce`=0, `reg_d`=0, `busy`=0 throughout. After release, the first grant goes to requester 0.
2. Single request: `req`=4'b0100, slice2=4'b1011:
   - next cycle `gnt`=4'b0100, `reg_ce`=1, `reg_d`=4'b1011, `owner`=2;
   - then `ack`=4'b0100, `reg_ce`=0;
   - then `busy`=0;
   - the register's `q`=4'b1011.
3. Contention: `req`=4'b1111 held (each requester drops on `ack`, re-raises 1 cycle later) → grant order 0,1,2,3,0 with `reg_ce` pulses 3 cycles apart. Data slices 4'b1000, 4'b0001, 4'b0011, 4'b1111 appear on `reg_d` in that order.
4. Wrap: after owner=3 completes, `req`=4'b1001 → `owner`=0. Then, with `req`=4'b1001 again, `owner`=3.
5. Data stability: slice1=4'b0110 latched, then slice1 changes to 4'b1001 during WRITE → `reg_d`=4'b0110 for the WRITE cycle and the register's `q`=4'b0110.
6. Abort: `clr` pulsed for 3 ns during WRITE → `reg_ce`, `gnt` and `busy` fall before the next edge, no `ack` appears, and `q` is unchanged. The request, still held, is granted again starting 1 cycle after release.

Source files
------------

// File: rtl/reg4_write_arbiter.sv
// Round-robin write arbiter for a shared ce-gated register.
// Grants one requester, drives a single write cycle, then acks.
module reg4_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] d_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   reg_ce,
  output logic [WIDTH-1:0]       reg_d,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [N_REQ-1:0] gnt_nxt;
  logic [N_REQ-1:0] ack_nxt;
  logic             reg_ce_nxt;
  logic [WIDTH-1:0] reg_d_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = d_in[i*WIDTH +: WIDTH];
  end

  // First set request strictly after rr, wrapping past N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    owner_nxt  = owner;
    gnt_nxt    = gnt;
    ack_nxt    = ack;
    reg_ce_nxt = reg_ce;
    reg_d_nxt  = reg_d;
    busy_nxt   = busy;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = WRITE;
          rr_nxt     = win;
          owner_nxt  = win;
          gnt_nxt    = N_REQ'(1) << win;
          reg_d_nxt  = slice[win];
          reg_ce_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end
      end
      WRITE: begin
        state_nxt  = ACK;
        reg_ce_nxt = 1'b0;
        ack_nxt    = N_REQ'(1) << owner;
      end
      ACK: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr     <= IDX_W'(N_REQ - 1);
      owner  <= '0;
      gnt    <= '0;
      ack    <= '0;
      reg_ce <= 1'b0;
      reg_d  <= '0;
      busy   <= 1'b0;
    end else begin
      rr     <= rr_nxt;
      owner  <= owner_nxt;
      gnt    <= gnt_nxt;
      ack    <= ack_nxt;
      reg_ce <= reg_ce_nxt;
      reg_d  <= reg_d_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule
